// File: rtl/ring_flasher_16.sv
// 16-LED ring flasher: while repeat_signal is high, lights the ring clockwise in
// overlapping 8-on/4-off bursts until all LEDs are lit, then clears and restarts.
module ring_flasher_16 #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        repeat_signal,
  output logic [15:0] led
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ON_CW, OFF_CCW, ALL_ON} state_t;

  state_t        state;
  logic [3:0]    base;
  logic [2:0]    k;
  logic [PW-1:0] presc;

  logic          tick;
  logic [3:0]    on_pos;
  logic [3:0]    off_pos;
  logic [15:0]   led_set;
  logic [15:0]   led_clr;

  // Ring positions wrap naturally in 4 bits.
  assign tick    = (presc == PMAX);
  assign on_pos  = base + 4'(k);
  assign off_pos = base + 4'd7 - 4'(k);
  assign led_set = led | (16'h0001 << on_pos);
  assign led_clr = led & ~(16'h0001 << off_pos);

  // Sequencer: state advances only on prescaler ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
      k     <= '0;
      presc <= '0;
      led   <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        case (state)
          IDLE: begin
            led <= '0;
            if (repeat_signal) begin
              state <= ON_CW;
              base  <= '0;
              k     <= '0;
            end
          end
          ON_CW: begin
            led <= led_set;
            if (led_set == 16'hFFFF) begin
              state <= ALL_ON;
            end else if (k == 3'd7) begin
              state <= OFF_CCW;
              k     <= '0;
            end else begin
              k <= k + 3'd1;
            end
          end
          OFF_CCW: begin
            led <= led_clr;
            if (k == 3'd3) begin
              base  <= base + 4'd4;
              k     <= '0;
              state <= ON_CW;
            end else begin
              k <= k + 3'd1;
            end
          end
          ALL_ON: begin
            led   <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_flasher_16.sv
// Scoreboard bench for ring_flasher_16: expected LED patterns are derived from the
// documented pass (on 0..7, off 7..4, on 4..11, off 11..8, on 8..15, clear).
module tb_ring_flasher_16;

  logic        clk;
  logic        rst_n;
  logic        repeat_signal;
  logic [15:0] led1;
  logic [15:0] led4;

  ring_flasher_16 #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .repeat_signal(repeat_signal), .led(led1)
  );
  ring_flasher_16 #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .repeat_signal(repeat_signal), .led(led4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pass [0:34];

  // led after tick t of a pass (index 0 = before the first tick)
  task automatic build_pass();
    logic [15:0] v;
    logic [15:0] one;
    int idx;
    int b;
    v = '0;
    one = 16'h0001;
    exp_pass[0] = '0;
    exp_pass[1] = '0;
    idx = 2;
    for (int r = 0; r < 3; r++) begin
      b = 4 * r;
      for (int j = 0; j < 8; j++) begin
        v = v | (one << ((b + j) % 16));
        exp_pass[idx] = v;
        idx++;
      end
      if (r < 2) begin
        for (int j = 0; j < 4; j++) begin
          v = v & ~(one << ((b + 7 - j) % 16));
          exp_pass[idx] = v;
          idx++;
        end
      end
    end
    exp_pass[34] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with repeat_signal held at rs; releases on a falling edge.
  task automatic apply_reset(input logic rs);
    @(negedge clk);
    rst_n = 1'b0;
    repeat_signal = rs;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    @(negedge clk);
    rst_n = 1'b0;
    repeat_signal = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (led1 !== 16'h0000 || led4 !== 16'h0000)
        $display("FAIL reset_hold cycle %0d: led1=%h led4=%h expected 0000", c, led1, led4);
      else n_pass++;
    end
    @(negedge clk);
    repeat_signal = 1'b0;
    rst_n = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      exp_q.push_back(16'h0000);
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (led1 !== e || led4 !== e)
        $display("FAIL reset_idle edge %0d: led1=%h led4=%h expected %h", c, led1, led4, e);
      else n_pass++;
    end
  endtask

  task automatic test_full_pass();
    logic [15:0] e;
    int ones;
    ones = 0;
    apply_reset(1'b0);
    repeat_signal = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      exp_q.push_back(exp_pass[c]);
      step();
      e = exp_q.pop_front();
      if (led1 === 16'hFFFF) ones++;
      n_checks++;
      if (led1 !== e) $display("FAIL full_pass edge %0d: led=%h expected %h", c, led1, e);
      else n_pass++;
    end
    n_checks++;
    if (ones != 1) $display("FAIL full_pass_allon_count: got %0d expected 1", ones);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int ones;
    ones = 0;
    apply_reset(1'b0);
    repeat_signal = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      exp_q.push_back(exp_pass[((c - 1) % 34) + 1]);
      step();
      e = exp_q.pop_front();
      if (led1 === 16'hFFFF) ones++;
      n_checks++;
      if (led1 !== e) $display("FAIL back_to_back edge %0d: led=%h expected %h", c, led1, e);
      else n_pass++;
    end
    n_checks++;
    if (ones != 2) $display("FAIL back_to_back_allon_count: got %0d expected 2", ones);
    else n_pass++;
  endtask

  task automatic test_early_release();
    logic [15:0] e;
    apply_reset(1'b0);
    repeat_signal = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      exp_q.push_back(c <= 34 ? exp_pass[c] : 16'h0000);
      step();
      if (c == 5) repeat_signal = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (led1 !== e) $display("FAIL early_release edge %0d: led=%h expected %h", c, led1, e);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    apply_reset(1'b0);
    repeat_signal = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      exp_q.push_back(exp_pass[c]);
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (led1 !== e) $display("FAIL async_pre edge %0d: led=%h expected %h", c, led1, e);
      else n_pass++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (led1 !== 16'h0000 || led4 !== 16'h0000)
      $display("FAIL async_reset_immediate: led1=%h led4=%h expected 0000", led1, led4);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      exp_q.push_back(exp_pass[c]);
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (led1 !== e) $display("FAIL async_restart edge %0d: led=%h expected %h", c, led1, e);
      else n_pass++;
    end
  endtask

  task automatic test_prescaler();
    logic [15:0] e;
    apply_reset(1'b0);
    repeat_signal = 1'b1;
    for (int c = 1; c <= 136; c++) begin
      exp_q.push_back(exp_pass[c / 4]);
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (led4 !== e) $display("FAIL prescaler clock %0d: led=%h expected %h", c, led4, e);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat_signal = 1'b0;
    build_pass();
    test_reset();
    test_full_pass();
    test_back_to_back();
    test_early_release();
    test_async_reset();
    test_prescaler();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ring_flasher_16.md
# ring_flasher_16

16-LED ring-flasher sequencer driving a circular ring of lamps from one request input. While `repeat_signal` is high, it lights the ring clockwise in overlapping bursts until all 16 LEDs are on, then clears and restarts. It sits between a board-level request or switch input and the LED pins. All outputs are registered.

## Interface
- `TICK_DIV`, default 1: clock cycles per sequencer step. Must be ≥1. With 1, every clock edge is a step.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `repeat_signal`  in  1: start/repeat request, level-sensitive.
- `led`  out  16: lamp drive, 1 = on. `led[i]` is ring position i; increasing index is clockwise; position 15 wraps to 0.

## Operation
- Internal registers:
  - `state` ∈ {IDLE, ON_CW, OFF_CCW, ALL_ON}.
  - `base`: 4-bit ring position.
  - `k`: 3-bit step counter.
  - prescaler counter.
- All position arithmetic is modulo 16 (4-bit natural wrap).
- A *tick* is one clock in which the prescaler is at TICK_DIV−1. The prescaler then wraps to 0. State changes only on ticks.
- IDLE, on each tick:
  - `led` = 0.
  - If `repeat_signal`=1: go to ON_CW with `base`=0, `k`=0. No LED change on this tick.
- ON_CW, on each tick:
  - Set `led[base+k]`=1.
  - If the updated `led` equals 16'hFFFF: go to ALL_ON.
  - Else if `k`=7: go to OFF_CCW with `k`=0.
  - Else increment `k`.
- OFF_CCW, on each tick:
  - Clear `led[base+7−k]`.
  - If `k`=3: `base` += 4, `k`=0, go to ON_CW.
  - Else increment `k`.
- ALL_ON, on the next tick: `led`=0, go to IDLE.
- Net effect of one pass:
  - Round 1: on 0→7, then off 7→4.
  - Round 2: on 4→11, then off 11→8.
  - Round 3: on 8→15, which reaches all-on.
  - Then a full clear.
- `repeat_signal` is sampled only in IDLE.
  - A started sequence always runs to completion, even if `repeat_signal` drops mid-sequence.
  - If `repeat_signal` is still high at the IDLE tick after ALL_ON, a new pass starts immediately.
  - If it is low, the block stays in IDLE with `led`=0.

## Timing
- Reset (asynchronous, active-low) forces, without waiting for `clk`:
  - `led`=16'h0000.
  - `state`=IDLE.
  - `base`=0, `k`=0, prescaler=0.
- Reset asserted mid-sequence aborts the sequence immediately.
- After reset release, the first rising edge with the prescaler at TICK_DIV−1 is a tick. For TICK_DIV=1, that is the first edge.
- Pass length is 34 ticks, numbered from the IDLE tick that sees `repeat_signal`=1 as tick 1.
  - Tick 1: IDLE → ON_CW; `led` is still 0.
  - Ticks 2–9: LEDs 0..7 turn on, one per tick. After tick 9, `led`=16'h00FF.
  - Ticks 10–13: LEDs 7,6,5,4 turn off. After tick 13, `led`=16'h000F.
  - Ticks 14–21: LEDs 4..11 turn on → 16'h0FFF.
  - Ticks 22–25: LEDs 11..8 turn off → 16'h00FF.
  - Ticks 26–33: LEDs 8..15 turn on. After tick 33, `led`=16'hFFFF and state is ALL_ON.
  - Tick 34: `led`=16'h0000; state is IDLE.
  - Tick 35 is an IDLE tick: it restarts the pass if `repeat_signal`=1.
- Exactly one LED changes per tick in ON_CW/OFF_CCW. No LED changes between ticks.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `repeat_signal`=1 → `led`=0 throughout. After release with `repeat_signal`=0 for 50 cycles → `led` stays 0.
- **Full pass (TICK_DIV=1):** raise `repeat_signal` and hold it. `led` after edges 1, 9, 13, 21, 25, 33, 34 must be 0000, 00FF, 000F, 0FFF, 00FF, FFFF, 0000 (hex). `led` must be all-ones exactly once per pass.
- **Continuous repeat:** `repeat_signal` held high for 100 cycles → passes restart back-to-back every 34 cycles; the second pass reaches FFFF after edge 67.
- **Early release:** drop `repeat_signal` at edge 5 → the pass still completes (FFFF after edge 33, 0 after 34). `led` then stays 0 while `repeat_signal` remains low.
- **Async reset mid-pass:** pull `rst_n` low between edges at edge 20 → `led`=0 immediately, before the next edge. After release with `repeat_signal`=1, a new pass restarts from LED 0.
- **Prescaler:** TICK_DIV=4 → each LED transition occurs every 4 clocks; all-on after clock 132, clear after clock 136.
